// File: rtl/cache_data_bank.sv
// cache_data_bank: multi-way cache line store with parallel all-way read,
// byte-strobed single-word writes and a beat-by-beat refill line buffer
// that commits a complete line to one way in a single cycle.
module cache_data_bank #(
  parameter int NUM_WAYS       = 4,
  parameter int SET_ADDR_WIDTH = 3,
  parameter int LINE_WIDTH     = 256,
  parameter int WORD_WIDTH     = 32,
  parameter int READ_REG       = 0
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [SET_ADDR_WIDTH-1:0]                  rd_set_i,
  output logic [NUM_WAYS*LINE_WIDTH-1:0]             rd_data_o,
  input  logic                                       wr_valid_i,
  output logic                                       wr_ready_o,
  input  logic [$clog2(NUM_WAYS)-1:0]                wr_way_i,
  input  logic [SET_ADDR_WIDTH-1:0]                  wr_set_i,
  input  logic [$clog2(LINE_WIDTH/WORD_WIDTH)-1:0]   wr_word_i,
  input  logic [WORD_WIDTH/8-1:0]                    wr_strb_i,
  input  logic [WORD_WIDTH-1:0]                      wr_data_i,
  input  logic                                       fill_start_i,
  input  logic [$clog2(NUM_WAYS)-1:0]                fill_way_i,
  input  logic [SET_ADDR_WIDTH-1:0]                  fill_set_i,
  input  logic                                       fill_beat_valid_i,
  input  logic [WORD_WIDTH-1:0]                      fill_beat_data_i,
  output logic                                       fill_beat_ready_o,
  output logic                                       fill_busy_o,
  output logic                                       fill_done_o
);

  localparam int BEATS  = LINE_WIDTH / WORD_WIDTH;
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int CNT_W  = $clog2(BEATS);
  localparam int SETS   = 1 << SET_ADDR_WIDTH;
  localparam int STRB_W = WORD_WIDTH / 8;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [WAY_W-1:0]          fway_q, fway_d;
  logic [SET_ADDR_WIDTH-1:0] fset_q, fset_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      bready_q, bready_d;

  logic                      beat_acc_s;
  logic                      wr_ready_s;
  logic                      wr_acc_s;
  logic [LINE_WIDTH-1:0]     wr_line_s;
  logic [NUM_WAYS*LINE_WIDTH-1:0] rd_arr_s;

  // Line storage (never reset) and the refill assembly buffer.
  logic [LINE_WIDTH-1:0]     mem_q [NUM_WAYS][SETS];
  logic [LINE_WIDTH-1:0]     buf_q;

  // State register plus registered status outputs; reset aborts any refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      fway_q   <= {WAY_W{1'b0}};
      fset_q   <= {SET_ADDR_WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fway_q   <= fway_d;
      fset_q   <= fset_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bready_q <= bready_d;
    end
  end

  // Next-state logic: latch target on start, count beats, commit after last.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fway_d  = fway_q;
    fset_d  = fset_q;
    case (state_q)
      S_IDLE: begin
        if (fill_start_i) begin
          state_d = S_FILL;
          cnt_d   = {CNT_W{1'b0}};
          fway_d  = fill_way_i;
          fset_d  = fill_set_i;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (fill_beat_valid_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = S_COMMIT;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_FILL;
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: handshakes from current state, status from next state.
  always_comb begin
    beat_acc_s = 1'b0;
    wr_ready_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        wr_ready_s = 1'b1;
      end
      S_FILL: begin
        beat_acc_s = fill_beat_valid_i;
        // A word write may not target the line being refilled.
        wr_ready_s = !((wr_way_i == fway_q) && (wr_set_i == fset_q));
      end
      S_COMMIT: begin
        wr_ready_s = 1'b0;
      end
      default: begin
        wr_ready_s = 1'b0;
      end
    endcase
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_COMMIT);
    bready_d = (state_d == S_FILL);
    wr_acc_s = wr_valid_i && wr_ready_s;
  end

  // Byte-strobe merge of the write word into a copy of the target line.
  always_comb begin
    wr_line_s = mem_q[wr_way_i][wr_set_i];
    for (int b = 0; b < STRB_W; b++) begin
      wr_line_s[wr_word_i*WORD_WIDTH + b*8 +: 8] =
        wr_strb_i[b] ? wr_data_i[b*8 +: 8] : wr_line_s[wr_word_i*WORD_WIDTH + b*8 +: 8];
    end
  end

  // Refill buffer: each accepted beat lands at its counter slot.
  always_ff @(posedge clk) begin
    if (!rst && beat_acc_s) begin
      buf_q[cnt_q*WORD_WIDTH +: WORD_WIDTH] <= fill_beat_data_i;
    end
  end

  // Array write port: commit and word writes never coincide (COMMIT stalls writes).
  always_ff @(posedge clk) begin
    if (!rst && (state_q == S_COMMIT)) begin
      mem_q[fway_q][fset_q] <= buf_q;
    end else if (wr_acc_s) begin
      mem_q[wr_way_i][wr_set_i] <= wr_line_s;
    end
  end

  // Gather every way of the requested set.
  always_comb begin
    rd_arr_s = {(NUM_WAYS*LINE_WIDTH){1'b0}};
    for (int w = 0; w < NUM_WAYS; w++) begin
      rd_arr_s[w*LINE_WIDTH +: LINE_WIDTH] = mem_q[w][rd_set_i];
    end
  end

  generate
    if (READ_REG != 0) begin : g_rd_reg
      logic [NUM_WAYS*LINE_WIDTH-1:0] rd_q;
      // Registered read samples pre-write array contents (read-old).
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_q <= {(NUM_WAYS*LINE_WIDTH){1'b0}};
        end else begin
          rd_q <= rd_arr_s;
        end
      end
      assign rd_data_o = rd_q;
    end else begin : g_rd_comb
      assign rd_data_o = rd_arr_s;
    end
  endgenerate

  assign wr_ready_o        = wr_ready_s;
  assign fill_beat_ready_o = bready_q;
  assign fill_busy_o       = busy_q;
  assign fill_done_o       = done_q;

endmodule

// File: tb/tb_cache_data_bank.sv
// Bench for cache_data_bank: one combinational-read and one registered-read
// instance share stimulus; a transaction-level line model predicts reads.
module tb_cache_data_bank;
  localparam int NW = 4;
  localparam int SW = 3;
  localparam int LW = 256;
  localparam int WW = 32;
  localparam int BEATS = 8;
  localparam int SETS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [SW-1:0] rd_set;
  logic wr_valid;
  logic [1:0] wr_way;
  logic [SW-1:0] wr_set;
  logic [2:0] wr_word;
  logic [3:0] wr_strb;
  logic [WW-1:0] wr_data;
  logic fill_start;
  logic [1:0] fill_way;
  logic [SW-1:0] fill_set;
  logic fill_beat_valid;
  logic [WW-1:0] fill_beat_data;

  logic [NW*LW-1:0] rd0, rd1;
  logic wr_ready0, wr_ready1, bready0, bready1, busy0, busy1, done0, done1;

  cache_data_bank #(.NUM_WAYS(NW), .SET_ADDR_WIDTH(SW), .LINE_WIDTH(LW), .WORD_WIDTH(WW), .READ_REG(0)) dut0 (
    .clk(clk), .rst(rst), .rd_set_i(rd_set), .rd_data_o(rd0),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready0), .wr_way_i(wr_way), .wr_set_i(wr_set),
    .wr_word_i(wr_word), .wr_strb_i(wr_strb), .wr_data_i(wr_data),
    .fill_start_i(fill_start), .fill_way_i(fill_way), .fill_set_i(fill_set),
    .fill_beat_valid_i(fill_beat_valid), .fill_beat_data_i(fill_beat_data),
    .fill_beat_ready_o(bready0), .fill_busy_o(busy0), .fill_done_o(done0));

  cache_data_bank #(.NUM_WAYS(NW), .SET_ADDR_WIDTH(SW), .LINE_WIDTH(LW), .WORD_WIDTH(WW), .READ_REG(1)) dut1 (
    .clk(clk), .rst(rst), .rd_set_i(rd_set), .rd_data_o(rd1),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready1), .wr_way_i(wr_way), .wr_set_i(wr_set),
    .wr_word_i(wr_word), .wr_strb_i(wr_strb), .wr_data_i(wr_data),
    .fill_start_i(fill_start), .fill_way_i(fill_way), .fill_set_i(fill_set),
    .fill_beat_valid_i(fill_beat_valid), .fill_beat_data_i(fill_beat_data),
    .fill_beat_ready_o(bready1), .fill_busy_o(busy1), .fill_done_o(done1));

  // Reference model: line contents plus expected registered-read value.
  logic [LW-1:0] mem_m [NW][SETS];
  logic [LW-1:0] exp_rd1 [NW];
  int n_pass = 0;
  int n_total = 0;
  bit rd_chk_en = 1'b0;
  int rd_fix = -1;
  bit pend_commit = 1'b0;
  int pc_way, pc_set;
  logic [LW-1:0] pc_line;

  typedef struct {
    int            word;
    logic [3:0]    strb;
    logic [WW-1:0] data;
    logic [WW-1:0] exp;
  } wvec_t;
  wvec_t tbl [6];

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  function automatic logic [LW-1:0] merge(input logic [LW-1:0] line, input int word,
                                          input logic [3:0] strb, input logic [WW-1:0] data);
    logic [LW-1:0] r;
    r = line;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[word*WW + b*8 +: 8] = data[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] r;
    for (int k = 0; k < BEATS; k++) r[k*WW +: WW] = $urandom;
    return r;
  endfunction

  task automatic set_wr(input bit v, input int way, input int set, input int word,
                        input logic [3:0] strb, input logic [WW-1:0] data);
    wr_valid = v; wr_way = way[1:0]; wr_set = set[SW-1:0]; wr_word = word[2:0];
    wr_strb = strb; wr_data = data;
  endtask

  // One clock: update model at the edge, then compare both read ports.
  task automatic tick(input bit wr_acc);
    @(posedge clk);
    for (int w = 0; w < NW; w++) exp_rd1[w] = rst ? '0 : mem_m[w][rd_set];
    if (pend_commit) begin
      mem_m[pc_way][pc_set] = pc_line;
      pend_commit = 1'b0;
    end
    if (wr_acc) mem_m[wr_way][wr_set] = merge(mem_m[wr_way][wr_set], int'(wr_word), wr_strb, wr_data);
    #1;
    rd_set = (rd_fix < 0) ? SW'($urandom_range(0, SETS-1)) : SW'(rd_fix);
    #1;
    if (rd_chk_en) begin
      for (int w = 0; w < NW; w++) begin
        check($sformatf("rd_comb_w%0d_s%0d", w, rd_set), rd0[w*LW +: LW], mem_m[w][rd_set]);
        check($sformatf("rd_reg_w%0d", w), rd1[w*LW +: LW], exp_rd1[w]);
      end
    end
  endtask

  // Complete refill with optional fixed gap, random gaps, or reset abort.
  task automatic do_fill(input int way, input int set, input logic [LW-1:0] line,
                         input int gap_at, input int gap_len, input int abort_at,
                         input bit rnd, input int exp_done_cyc);
    int cyc, busy_cnt, i, g;
    bit v;
    cyc = 0; busy_cnt = 0; i = 0; g = 0;
    rd_fix = set;
    fill_start = 1'b1; fill_way = way[1:0]; fill_set = set[SW-1:0]; fill_beat_valid = 1'b0;
    #1;
    check("start_idle_busy", busy0, 1'b0);
    tick(1'b0);
    cyc = 1;
    fill_start = 1'b0;
    while (i < BEATS) begin
      if (g > 0) begin v = 1'b0; g--; end
      else if (rnd) v = ($urandom_range(0, 3) != 0);
      else v = 1'b1;
      fill_beat_valid = v; fill_beat_data = line[i*WW +: WW];
      #1;
      check("fill_beat_ready", {bready0, bready1}, 2'b11);
      check("fill_busy", {busy0, busy1}, 2'b11);
      check("fill_done_early", {done0, done1}, 2'b00);
      if (busy0) busy_cnt++;
      tick(1'b0);
      cyc++;
      if (v) begin
        if (i == gap_at) g = gap_len;
        if (i == abort_at) begin
          rst = 1'b1; fill_beat_valid = 1'b0;
          tick(1'b0);
          rst = 1'b0;
          #1;
          check("abort_busy", busy0, 1'b0);
          check("abort_done", done0, 1'b0);
          check("abort_beat_ready", bready0, 1'b0);
          rd_fix = -1;
          return;
        end
        i++;
      end
    end
    fill_beat_valid = 1'b0;
    #1;
    check("commit_done", {done0, done1}, 2'b11);
    check("commit_busy", busy0, 1'b1);
    check("commit_beat_ready", bready0, 1'b0);
    if (busy0) busy_cnt++;
    if (exp_done_cyc >= 0) begin
      check("done_cycle", cyc, exp_done_cyc);
      check("busy_cycles", busy_cnt, exp_done_cyc);
    end
    pend_commit = 1'b1; pc_way = way; pc_set = set; pc_line = line;
    tick(1'b0);
    #1;
    check("post_done", done0, 1'b0);
    check("post_busy", busy0, 1'b0);
    rd_fix = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [LW-1:0] l1, lf, old;
    tbl[0] = '{6, 4'b0101, 32'hAABBCCDD, 32'h00BB00DD};
    tbl[1] = '{6, 4'b1010, 32'h11223344, 32'h11BB33DD};
    tbl[2] = '{6, 4'b0000, 32'hFFFFFFFF, 32'h11BB33DD};
    tbl[3] = '{0, 4'b1111, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[4] = '{7, 4'b1000, 32'h5A000000, 32'h5A000000};
    tbl[5] = '{0, 4'b0001, 32'h00000012, 32'hDEADBE12};

    rst = 1'b1; rd_set = '0; fill_start = 1'b0; fill_way = '0; fill_set = '0;
    fill_beat_valid = 1'b0; fill_beat_data = '0;
    set_wr(1'b0, 0, 0, 0, 4'b0000, 32'h0);
    tick(1'b0); tick(1'b0);
    for (int w = 0; w < NW; w++) check("reset_rd_reg", rd1[w*LW +: LW], '0);
    check("reset_busy", busy0, 1'b0);
    check("reset_done", done0, 1'b0);
    check("reset_beat_ready", bready0, 1'b0);
    check("reset_wr_ready", wr_ready0, 1'b1);
    rst = 1'b0;

    // Give every line a known value.
    for (int w = 0; w < NW; w++)
      for (int s = 0; s < SETS; s++)
        do_fill(w, s, rnd_line(), -1, 0, -1, 1'b0, -1);
    rd_chk_en = 1'b1;

    // Beats offered while idle are not consumed.
    fill_beat_valid = 1'b1; #1;
    check("idle_beat_ready", bready0, 1'b0);
    tick(1'b0);
    check("idle_no_start", busy0, 1'b0);
    fill_beat_valid = 1'b0;

    // Back-to-back refill of way2 set5.
    for (int k = 0; k < BEATS; k++) l1[k*WW +: WW] = (k + 1) * 32'h11111111;
    do_fill(2, 5, l1, -1, 0, -1, 1'b0, 9);
    rd_set = 3'd5; #1;
    check("fill_way2_set5", rd0[2*LW +: LW], l1);

    // Same data with a 3-cycle gap after the 4th beat.
    do_fill(2, 4, l1, 3, 3, -1, 1'b0, 12);
    rd_set = 3'd4; #1;
    check("gap_fill_way2_set4", rd0[2*LW +: LW], l1);

    // Table of strobed word writes onto a zeroed line.
    do_fill(1, 3, '0, -1, 0, -1, 1'b0, 9);
    rd_fix = 3;
    for (int t = 0; t < 6; t++) begin
      set_wr(1'b1, 1, 3, tbl[t].word, tbl[t].strb, tbl[t].data);
      #1;
      check("tbl_wr_ready", {wr_ready0, wr_ready1}, 2'b11);
      tick(1'b1);
      set_wr(1'b0, 0, 0, 0, 4'b0000, 32'h0);
      check($sformatf("tbl_word_%0d", t), rd0[LW + tbl[t].word*WW +: WW], tbl[t].exp);
    end
    rd_fix = -1;

    // Word writes racing a refill of way0 set1, with an ignored second start.
    lf = rnd_line();
    rd_fix = 1;
    fill_start = 1'b1; fill_way = 2'd0; fill_set = 3'd1;
    tick(1'b0);
    fill_start = 1'b0;
    for (int i = 0; i < BEATS; i++) begin
      fill_beat_valid = 1'b1; fill_beat_data = lf[i*WW +: WW];
      if (i == 1) begin
        set_wr(1'b1, 0, 1, 2, 4'b1111, 32'hCAFEF00D); #1;
        check("same_line_wr_ready", wr_ready0, 1'b0);
        tick(1'b0);
      end else if (i == 2) begin
        set_wr(1'b1, 3, 1, 5, 4'b1111, 32'h01234567); #1;
        check("other_way_wr_ready", wr_ready0, 1'b1);
        tick(1'b1);
      end else if (i == 3) begin
        fill_start = 1'b1; fill_way = 2'd1; fill_set = 3'd2;
        tick(1'b0);
        fill_start = 1'b0;
      end else begin
        tick(1'b0);
      end
      set_wr(1'b0, 0, 0, 0, 4'b0000, 32'h0);
    end
    fill_beat_valid = 1'b0;
    set_wr(1'b1, 0, 1, 3, 4'b1111, 32'h89ABCDEF); #1;
    check("commit_wr_ready", wr_ready0, 1'b0);
    check("commit_done_race", done0, 1'b1);
    pend_commit = 1'b1; pc_way = 0; pc_set = 1; pc_line = lf;
    tick(1'b0);
    #1;
    check("held_wr_ready", wr_ready0, 1'b1);
    tick(1'b1);
    set_wr(1'b0, 0, 0, 0, 4'b0000, 32'h0);
    check("held_wr_word3", rd0[3*WW +: WW], 32'h89ABCDEF);
    rd_fix = -1;

    // Reset after the 5th beat, then a fresh refill of the same line.
    do_fill(3, 7, rnd_line(), -1, 0, 4, 1'b0, -1);
    do_fill(3, 7, rnd_line(), -1, 0, -1, 1'b0, 9);

    // Registered read shows old data one cycle after the write edge.
    rd_fix = 6;
    tick(1'b0);
    old = mem_m[1][6];
    set_wr(1'b1, 1, 6, 2, 4'b1111, ~old[2*WW +: WW]);
    tick(1'b1);
    set_wr(1'b0, 0, 0, 0, 4'b0000, 32'h0);
    check("rr_old", rd1[LW +: LW], old);
    tick(1'b0);
    check("rr_new", rd1[LW +: LW], merge(old, 2, 4'b1111, ~old[2*WW +: WW]));
    rd_fix = -1;

    // Random traffic: idle word writes and refills with random beat gaps.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        set_wr(1'b1, $urandom_range(0, NW-1), $urandom_range(0, SETS-1), $urandom_range(0, BEATS-1),
               4'($urandom_range(0, 15)), $urandom);
        #1;
        check("rand_wr_ready", wr_ready0, 1'b1);
        tick(1'b1);
        set_wr(1'b0, 0, 0, 0, 4'b0000, 32'h0);
      end else begin
        do_fill($urandom_range(0, NW-1), $urandom_range(0, SETS-1), rnd_line(), -1, 0, -1, 1'b1, -1);
      end
    end
    tick(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/cache_data_bank.md
Name: cache_data_bank

Overview:
Parametrised multi-way cache data store for the custom CPU I/D caches. It holds NUM_WAYS line arrays and returns all ways of a set in parallel for hit selection. It supports byte-strobed single-word writes for store hits. It also assembles memory refill bursts beat-by-beat in a line buffer, then commits the complete line to one way in a single cycle.

Parameters:
NUM_WAYS, 4, number of ways (power of 2, >=2)
SET_ADDR_WIDTH, 3, set index width; sets = 2^SET_ADDR_WIDTH
LINE_WIDTH, 256, bits per line
WORD_WIDTH, 32, bits per word/refill beat; BEATS = LINE_WIDTH/WORD_WIDTH (power of 2)
READ_REG, 0, 0 = combinational read; 1 = one-cycle registered read

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
rd_set  in  SET_ADDR_WIDTH  read set index
rd_data  out  NUM_WAYS*LINE_WIDTH  way w occupies bits [w*LINE_WIDTH +: LINE_WIDTH]
wr_valid  in  1  word-write request
wr_ready  out  1  word write accepted this cycle
wr_way  in  log2(NUM_WAYS)  target way
wr_set  in  SET_ADDR_WIDTH  target set
wr_word  in  log2(BEATS)  word offset in line
wr_strb  in  WORD_WIDTH/8  byte enables
wr_data  in  WORD_WIDTH  write data
fill_start  in  1  begin refill (accepted only when idle)
fill_way  in  log2(NUM_WAYS)  refill target way
fill_set  in  SET_ADDR_WIDTH  refill target set
fill_beat_valid  in  1  refill beat present
fill_beat_data  in  WORD_WIDTH  refill beat
fill_beat_ready  out  1  beat accepted when valid&ready
fill_busy  out  1  refill in progress (FILL or COMMIT)
fill_done  out  1  one-cycle pulse in the commit cycle

Behaviour:
- Array contents are not reset. Reset clears the FSM to IDLE, the beat counter to 0, fill_done to 0 and the registered rd_data (READ_REG=1) to 0.
- rst mid-fill: fill is aborted, the buffer is discarded, and the array is not written.
- FSM states: IDLE, FILL, COMMIT.
  - IDLE: fill_start=1 latches fill_way/fill_set and clears the counter, then goes to FILL.
  - FILL: fill_beat_ready=1. Each valid&ready beat is stored at buffer[cnt*WORD_WIDTH +: WORD_WIDTH] and cnt increments. The beat with cnt==BEATS-1 moves the FSM to COMMIT.
  - COMMIT: the whole buffer is written to array[latched way][latched set], fill_done=1, and the FSM returns to IDLE next cycle.
- fill_busy=1 in FILL and COMMIT. fill_start is ignored outside IDLE. fill_beat_ready=0 outside FILL, so beats there are not consumed.
- Back-to-back beats with no gaps: fill_start is taken at cycle 0, beats at cycles 1..BEATS, COMMIT at cycle BEATS+1. fill_start may be taken again in cycle BEATS+2.
- Beat gaps (fill_beat_valid=0) hold the counter. There is no timeout.
- Word write:
  - wr_ready = IDLE, or FILL with (wr_way,wr_set) != the latched fill target. wr_ready=0 in COMMIT.
  - On wr_valid&wr_ready, each byte b with wr_strb[b]=1 replaces byte b of word wr_word in the target line. Other bytes and words are unchanged. The write takes effect at the clock edge.
  - A write not accepted performs no change; the requester holds it.
- No two array writes ever occur in one cycle: COMMIT blocks word writes.
- Read, READ_REG=0: rd_data reflects the array at rd_set combinationally. A write at edge t is visible after edge t.
- Read, READ_REG=1: rd_data is registered at each edge from the array at rd_set, using pre-write contents (read-old). Written data appears one cycle later still.
- Reads are never blocked. Reading the set under refill returns old contents until after the COMMIT edge.
- wr_strb=0 with wr_valid: accepted, no change.

Test Plan:
- Reset, then fill way 2 set 5 with beats 0x11111111..0x88888888 consecutively. Required: fill_busy high for 9 cycles, fill_done pulse in cycle 9. Next cycle rd_set=5 gives way2 = {0x88888888,...,0x11111111}, beat 0 in the LSBs, and other ways unchanged.
- Fill with a 3-cycle gap after beat 4. Required: counter holds, commit occurs 3 cycles later, and data is identical.
- Word write way1 set3 word6, strb=4'b0101, data 0xAABBCCDD onto 0x00000000. Required: word6 = 0x00BB00DD and all other words unchanged.
- During FILL of way0 set1:
  - Word write to way0 set1: wr_ready=0, no change.
  - Word write to way3 set1: accepted immediately.
  - Word write held into COMMIT: stalled one cycle, accepted the next.
- Assert rst after the 5th beat. Required: fill_busy=0 next cycle, no fill_done, target line keeps old contents, and a new fill_start is accepted.
- READ_REG=1: write at edge t. Required: rd_data shows old data in the cycle after edge t and new data after edge t+1. After reset, rd_data=0.
